// File: rtl/bec_la_ctrl_gen.sv
// Logic-analyser front end for the BEC scalar-multiplication core: operand load, launch, key serialisation, result readback.
// Define BEC_WATCHDOG_EN to add a PROC timeout watchdog (parameter WDOG).
module bec_la_ctrl_gen #(
    parameter int OPW   = 163,
    parameter int CHUNK = 64,
    parameter int NOPS  = 7,
    parameter int NRES  = 2
`ifdef BEC_WATCHDOG_EN
    ,
    parameter int WDOG  = 1 << 20
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [127:0]        la_data_in,
    output logic [127:0]        la_data_out,
    input  logic                slv_done,
    input  logic                next_key,
    output logic                proc_start,
    output logic                master_ena_proc,
    output logic                ki,
    output logic [NOPS*OPW-1:0] op_bus,
    input  logic [NRES*OPW-1:0] res_bus
);
    localparam int NCH  = (OPW + CHUNK - 1) / CHUNK;
    localparam int NSL  = NOPS * NCH;
    localparam int EXTW = NCH * CHUNK;

    localparam logic [7:0] CMD_ENTER   = 8'h30;
    localparam logic [7:0] CMD_WRITE   = 8'h31;
    localparam logic [7:0] CMD_START   = 8'h41;
    localparam logic [7:0] CMD_READ    = 8'h50;
    localparam logic [7:0] CMD_RELEASE = 8'h5F;
    localparam logic [7:0] CMD_ABORT   = 8'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_PROC  = 2'b11,
        S_READ  = 2'b10
    } state_t;

    state_t           state_q;
    logic             err_q, last_tgl_q, ack_q, proc_start_q, ena_q;
    logic [NSL-1:0]   mask_q;
    logic [CHUNK-1:0] rdata_q;
    logic [OPW-1:0]   key_q;
    logic [OPW-1:0]   ops_q [NOPS];
    logic [OPW-1:0]   res_q [NRES];
`ifdef BEC_WATCHDOG_EN
    logic [31:0]      wdog_q;
`endif

    logic [7:0] cmd, idx, slice;
    logic       tgl, tgl_new, wr_ok, rd_ok;
    assign cmd     = la_data_in[127:120];
    assign idx     = la_data_in[119:112];
    assign slice   = la_data_in[111:104];
    assign tgl     = la_data_in[103];
    // A command is new only when its toggle differs from the last accepted one.
    assign tgl_new = (tgl != last_tgl_q);
    assign wr_ok   = (32'(idx) < NOPS) && (32'(slice) < NCH);
    assign rd_ok   = (32'(idx) < NRES) && (32'(slice) < NCH);

    logic [EXTW-1:0]  wr_ext, rd_ext;
    logic [CHUNK-1:0] rd_slice;
    logic [31:0]      pop;
    logic [7:0]       wcnt;

    always_comb begin
        wr_ext   = '0;
        rd_ext   = '0;
        rd_slice = '0;
        for (int i = 0; i < NOPS; i++)
            if (idx == i[7:0]) wr_ext[OPW-1:0] = ops_q[i];
        for (int i = 0; i < NRES; i++)
            if (idx == i[7:0]) rd_ext[OPW-1:0] = res_q[i];
        // Bits of the top slice beyond OPW-1 fall off when wr_ext is truncated.
        for (int k = 0; k < NCH; k++) begin
            if (slice == k[7:0]) begin
                wr_ext[k*CHUNK +: CHUNK] = la_data_in[CHUNK-1:0];
                rd_slice = rd_ext[k*CHUNK +: CHUNK];
            end
        end
        pop = '0;
        for (int s = 0; s < NSL; s++) pop = pop + 32'(mask_q[s]);
        wcnt = (pop > 32'd255) ? 8'hFF : pop[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            err_q        <= 1'b0;
            last_tgl_q   <= 1'b0;
            ack_q        <= 1'b0;
            proc_start_q <= 1'b0;
            ena_q        <= 1'b0;
            mask_q       <= '0;
            rdata_q      <= '0;
            key_q        <= '0;
            for (int i = 0; i < NOPS; i++) ops_q[i] <= '0;
            for (int i = 0; i < NRES; i++) res_q[i] <= '0;
`ifdef BEC_WATCHDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            proc_start_q <= 1'b0;
            if (tgl_new) begin
                last_tgl_q <= tgl;
                ack_q      <= tgl;
            end
            if (state_q == S_PROC && next_key) key_q <= {1'b0, key_q[OPW-1:1]};

            if (tgl_new && cmd == CMD_ABORT) begin
                state_q      <= S_IDLE;
                ena_q        <= 1'b0;
                proc_start_q <= 1'b0;
            end else if (state_q == S_PROC) begin
                if (tgl_new) err_q <= 1'b1;
                if (slv_done) begin
                    for (int i = 0; i < NRES; i++) res_q[i] <= res_bus[i*OPW +: OPW];
                    state_q <= S_READ;
                    ena_q   <= 1'b0;
                end
`ifdef BEC_WATCHDOG_EN
                else if (wdog_q == 32'(WDOG - 1)) begin
                    state_q <= S_IDLE;
                    ena_q   <= 1'b0;
                    err_q   <= 1'b1;
                end
                wdog_q <= wdog_q + 32'd1;
`endif
            end else if (tgl_new) begin
                case (cmd)
                    CMD_ENTER: begin
                        if (state_q == S_IDLE) begin
                            state_q <= S_WRITE;
                            mask_q  <= '0;
                            err_q   <= 1'b0;
                        end else err_q <= 1'b1;
                    end
                    CMD_WRITE: begin
                        if (state_q == S_WRITE && wr_ok) begin
                            for (int i = 0; i < NOPS; i++) begin
                                if (idx == i[7:0]) ops_q[i] <= wr_ext[OPW-1:0];
                                for (int k = 0; k < NCH; k++)
                                    if (idx == i[7:0] && slice == k[7:0]) mask_q[i*NCH+k] <= 1'b1;
                            end
                        end else err_q <= 1'b1;
                    end
                    CMD_START: begin
                        if (state_q == S_WRITE && (&mask_q)) begin
                            state_q      <= S_PROC;
                            key_q        <= ops_q[NOPS-1];
                            proc_start_q <= 1'b1;
                            ena_q        <= 1'b1;
`ifdef BEC_WATCHDOG_EN
                            wdog_q       <= '0;
`endif
                        end else err_q <= 1'b1;
                    end
                    CMD_READ: begin
                        if (state_q == S_READ) begin
                            rdata_q <= rd_ok ? rd_slice : '0;
                            if (!rd_ok) err_q <= 1'b1;
                        end else err_q <= 1'b1;
                    end
                    CMD_RELEASE: begin
                        if (state_q == S_READ) state_q <= S_IDLE;
                        else err_q <= 1'b1;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        la_data_out            = '0;
        la_data_out[127:126]   = state_q;
        la_data_out[125]       = err_q;
        la_data_out[124]       = ack_q;
        la_data_out[123:116]   = wcnt;
        la_data_out[CHUNK-1:0] = rdata_q;
    end

    for (genvar g = 0; g < NOPS; g++) begin : g_op
        assign op_bus[g*OPW +: OPW] = ops_q[g];
    end

    assign proc_start      = proc_start_q;
    assign master_ena_proc = ena_q;
    assign ki              = key_q[0];

    logic unused_bits;
    assign unused_bits = ^{la_data_in[102:CHUNK], wr_ext};
endmodule
